// File: rtl/srio_pkg.sv
// Shared SRIO logical-layer constants: packet types, AXI4-Stream widths and
// the tresp arbiter state encoding.
package srio_pkg;

    localparam logic [3:0] FTYPE_NREAD  = 4'h2;
    localparam logic [3:0] FTYPE_NWRITE = 4'h5;
    localparam logic [3:0] FTYPE_SWRITE = 4'h6;
    localparam logic [3:0] FTYPE_DOORB  = 4'hA;
    localparam logic [3:0] FTYPE_MESSG  = 4'hB;
    localparam logic [3:0] FTYPE_RESP   = 4'hD;

    localparam logic [3:0] TTYPE_NWRITE   = 4'h4;
    localparam logic [3:0] TTYPE_NWRITE_R = 4'h5;
    localparam logic [3:0] TTYPE_NREAD    = 4'h4;
    localparam logic [3:0] TTYPE_RESP_ND  = 4'h0;
    localparam logic [3:0] TTYPE_RESP_D   = 4'h8;

    localparam int unsigned AXIS_DATA_W = 64;
    localparam int unsigned AXIS_KEEP_W = 8;
    localparam int unsigned AXIS_USER_W = 32;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI4-Stream register slice carrying data, keep, user, last and a
// 1-bit source tag. Contents hold while the downstream stalls.
module axis_out_reg
    import srio_pkg::*;
(
    input  logic                   log_clk,
    input  logic                   log_rst,
    input  logic                   load,
    input  logic [AXIS_DATA_W-1:0] in_data,
    input  logic [AXIS_KEEP_W-1:0] in_keep,
    input  logic [AXIS_USER_W-1:0] in_user,
    input  logic                   in_last,
    input  logic                   in_tag,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [AXIS_DATA_W-1:0] out_data,
    output logic [AXIS_KEEP_W-1:0] out_keep,
    output logic [AXIS_USER_W-1:0] out_user,
    output logic                   out_last,
    output logic                   out_tag,
    output logic                   space
);

    logic                   valid_q;
    logic [AXIS_DATA_W-1:0] data_q;
    logic [AXIS_KEEP_W-1:0] keep_q;
    logic [AXIS_USER_W-1:0] user_q;
    logic                   last_q;
    logic                   tag_q;

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            tag_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
            keep_q  <= in_keep;
            user_q  <= in_user;
            last_q  <= in_last;
            tag_q   <= in_tag;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // A new beat may enter when empty or when the current one leaves this cycle.
    assign space     = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_user  = user_q;
    assign out_last  = last_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/srio_tresp_arb.sv
// Packet-atomic round-robin arbiter sharing the SRIO tresp channel between the
// doorbell responder (s0) and the NWRITE/NREAD response generator (s1).
module srio_tresp_arb
    import srio_pkg::*;
#(
    parameter int SIM = 1
) (
    input  logic                   log_clk,
    input  logic                   log_rst,
    input  logic                   s0_tvalid,
    output logic                   s0_tready,
    input  logic                   s0_tlast,
    input  logic [AXIS_DATA_W-1:0] s0_tdata,
    input  logic [AXIS_KEEP_W-1:0] s0_tkeep,
    input  logic [AXIS_USER_W-1:0] s0_tuser,
    input  logic                   s1_tvalid,
    output logic                   s1_tready,
    input  logic                   s1_tlast,
    input  logic [AXIS_DATA_W-1:0] s1_tdata,
    input  logic [AXIS_KEEP_W-1:0] s1_tkeep,
    input  logic [AXIS_USER_W-1:0] s1_tuser,
    input  logic                   tresp_tready_in,
    output logic                   tresp_tvalid_o,
    output logic                   tresp_tlast_o,
    output logic [AXIS_DATA_W-1:0] tresp_tdata_o,
    output logic [AXIS_KEEP_W-1:0] tresp_tkeep_o,
    output logic [AXIS_USER_W-1:0] tresp_tuser_o,
    output logic [1:0]             grant,
    output logic                   busy,
    output logic [15:0]            pkt_cnt0,
    output logic [15:0]            pkt_cnt1
);

    if (SIM < 0 || SIM > 1) begin : g_sim_chk
        $error("SIM must be 0 or 1");
    end

    logic [0:0] state_q, state_d;
    logic       rr_q, rr_d;
    logic [1:0] grant_q, grant_d;
    logic [15:0] cnt0_q, cnt1_q;

    logic                   sel;
    logic                   space;
    logic                   accept;
    logic                   in_last;
    logic [AXIS_DATA_W-1:0] in_data;
    logic [AXIS_KEEP_W-1:0] in_keep;
    logic [AXIS_USER_W-1:0] in_user;
    logic                   out_tag;
    logic                   out_hs_last;

    assign sel     = grant_q[1];
    assign in_last = sel ? s1_tlast : s0_tlast;
    assign in_data = sel ? s1_tdata : s0_tdata;
    assign in_keep = sel ? s1_tkeep : s0_tkeep;
    assign in_user = sel ? s1_tuser : s0_tuser;

    assign s0_tready = (state_q == ST_XFER) & grant_q[0] & space;
    assign s1_tready = (state_q == ST_XFER) & grant_q[1] & space;
    assign accept    = (s0_tready & s0_tvalid) | (s1_tready & s1_tvalid);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        case (state_q)
            ST_ARB: begin
                if (s0_tvalid | s1_tvalid) begin
                    state_d = ST_XFER;
                    if (s0_tvalid & s1_tvalid) begin
                        grant_d = rr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant_d = s1_tvalid ? 2'b10 : 2'b01;
                    end
                end
            end
            ST_XFER: begin
                // Packet ends on input-side tlast; the other source gets priority next.
                if (accept & in_last) begin
                    state_d = ST_ARB;
                    grant_d = 2'b00;
                    rr_d    = ~sel;
                end
            end
            default: begin
                state_d = ST_ARB;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            state_q <= ST_ARB;
            rr_q    <= 1'b0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
        end
    end

    axis_out_reg u_out_reg (
        .log_clk   (log_clk),
        .log_rst   (log_rst),
        .load      (accept),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_user   (in_user),
        .in_last   (in_last),
        .in_tag    (sel),
        .out_ready (tresp_tready_in),
        .out_valid (tresp_tvalid_o),
        .out_data  (tresp_tdata_o),
        .out_keep  (tresp_tkeep_o),
        .out_user  (tresp_tuser_o),
        .out_last  (tresp_tlast_o),
        .out_tag   (out_tag),
        .space     (space)
    );

    // Packets are counted as they leave, attributed by the tag stored with the beat.
    assign out_hs_last = tresp_tvalid_o & tresp_tready_in & tresp_tlast_o;

    always_ff @(posedge log_clk) begin
        if (log_rst) begin
            cnt0_q <= 16'h0000;
            cnt1_q <= 16'h0000;
        end else if (out_hs_last) begin
            if (out_tag) begin
                cnt1_q <= cnt1_q + 16'd1;
            end else begin
                cnt0_q <= cnt0_q + 16'd1;
            end
        end
    end

    assign grant    = grant_q;
    assign busy     = (|grant_q) | tresp_tvalid_o;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_srio_tresp_arb.sv
// Self-checking bench for srio_tresp_arb: directed latency/reset steps plus
// randomized packet traffic checked against a packet-level round-robin model.
module tb_srio_tresp_arb;

    logic        log_clk = 1'b0;
    logic        log_rst = 1'b1;
    logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic        s0_tready, s1_tready;
    logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic [63:0] s0_tdata = '0, s1_tdata = '0;
    logic [7:0]  s0_tkeep = '0, s1_tkeep = '0;
    logic [31:0] s0_tuser = '0, s1_tuser = '0;
    logic        tresp_tready_in = 1'b0;
    logic        tresp_tvalid_o, tresp_tlast_o;
    logic [63:0] tresp_tdata_o;
    logic [7:0]  tresp_tkeep_o;
    logic [31:0] tresp_tuser_o;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] pkt_cnt0, pkt_cnt1;

    srio_tresp_arb #(.SIM(1)) dut (
        .log_clk         (log_clk),
        .log_rst         (log_rst),
        .s0_tvalid       (s0_tvalid),
        .s0_tready       (s0_tready),
        .s0_tlast        (s0_tlast),
        .s0_tdata        (s0_tdata),
        .s0_tkeep        (s0_tkeep),
        .s0_tuser        (s0_tuser),
        .s1_tvalid       (s1_tvalid),
        .s1_tready       (s1_tready),
        .s1_tlast        (s1_tlast),
        .s1_tdata        (s1_tdata),
        .s1_tkeep        (s1_tkeep),
        .s1_tuser        (s1_tuser),
        .tresp_tready_in (tresp_tready_in),
        .tresp_tvalid_o  (tresp_tvalid_o),
        .tresp_tlast_o   (tresp_tlast_o),
        .tresp_tdata_o   (tresp_tdata_o),
        .tresp_tkeep_o   (tresp_tkeep_o),
        .tresp_tuser_o   (tresp_tuser_o),
        .grant           (grant),
        .busy            (busy),
        .pkt_cnt0        (pkt_cnt0),
        .pkt_cnt1        (pkt_cnt1)
    );

    always #5 log_clk = ~log_clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [31:0] user;
        logic        last;
        logic        src;
    } beat_t;

    beat_t src_q0[$];
    beat_t src_q1[$];
    beat_t exp_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          last_src_m = 1;
    logic [15:0] cnt_m0 = 16'h0, cnt_m1 = 16'h0;
    int          ready_pct = 100;
    int          gap_pct = 0;
    int          stall_lo = 0, stall_hi = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        log_rst = 1'b1;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        tresp_tready_in = 1'b0;
        repeat (3) @(negedge log_clk);
        log_rst = 1'b0;
        src_q0.delete();
        src_q1.delete();
        exp_q.delete();
        last_src_m = 1;
        cnt_m0 = 16'h0;
        cnt_m1 = 16'h0;
    endtask

    task automatic add_packet(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'($urandom);
            b.user = $urandom;
            b.last = (i == len - 1);
            b.src  = src[0];
            if (src == 0) src_q0.push_back(b);
            else src_q1.push_back(b);
        end
    endtask

    // Packet-level round robin: alternate while both have packets, else drain the other.
    task automatic build_expected();
        beat_t c0[$];
        beat_t c1[$];
        beat_t b;
        int    pick;
        c0 = src_q0;
        c1 = src_q1;
        while (c0.size() > 0 || c1.size() > 0) begin
            if (c0.size() > 0 && c1.size() > 0) pick = (last_src_m == 0) ? 1 : 0;
            else pick = (c0.size() > 0) ? 0 : 1;
            do begin
                b = (pick == 0) ? c0.pop_front() : c1.pop_front();
                exp_q.push_back(b);
            end while (!b.last);
            last_src_m = pick;
        end
    endtask

    task automatic run_phase(input int budget);
        int          cyc = 0;
        bit          first0 = 1'b1, first1 = 1'b1;
        bit          prev_stall = 1'b0;
        logic [127:0] prev_out = '0;
        beat_t       e;
        build_expected();
        while ((src_q0.size() > 0 || src_q1.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge log_clk);
            if (src_q0.size() > 0) begin
                s0_tvalid = first0 || ($urandom_range(99) >= gap_pct);
                s0_tdata = src_q0[0].data; s0_tkeep = src_q0[0].keep;
                s0_tuser = src_q0[0].user; s0_tlast = src_q0[0].last;
            end else s0_tvalid = 1'b0;
            if (src_q1.size() > 0) begin
                s1_tvalid = first1 || ($urandom_range(99) >= gap_pct);
                s1_tdata = src_q1[0].data; s1_tkeep = src_q1[0].keep;
                s1_tuser = src_q1[0].user; s1_tlast = src_q1[0].last;
            end else s1_tvalid = 1'b0;
            tresp_tready_in = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0
                                                                 : ($urandom_range(99) < ready_pct);
            #1;
            chk("pkt_cnt0", 128'(pkt_cnt0), 128'(cnt_m0));
            chk("pkt_cnt1", 128'(pkt_cnt1), 128'(cnt_m1));
            if (prev_stall)
                chk("hold_stable", 128'({tresp_tvalid_o, tresp_tdata_o, tresp_tkeep_o,
                                         tresp_tuser_o, tresp_tlast_o}), prev_out);
            if (tresp_tvalid_o && !tresp_tready_in)
                chk("tready_when_full", 128'({s0_tready, s1_tready}), 128'(0));
            if (tresp_tvalid_o && tresp_tready_in) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 128'({tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o, tresp_tlast_o}),
                        128'({e.data, e.keep, e.user, e.last}));
                    if (e.last) begin
                        if (e.src) cnt_m1 = cnt_m1 + 16'd1;
                        else cnt_m0 = cnt_m0 + 16'd1;
                    end
                end
            end
            prev_stall = tresp_tvalid_o && !tresp_tready_in;
            prev_out = 128'({tresp_tvalid_o, tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o,
                             tresp_tlast_o});
            if (s0_tvalid && s0_tready) begin
                first0 = src_q0[0].last;
                void'(src_q0.pop_front());
            end
            if (s1_tvalid && s1_tready) begin
                first1 = src_q1[0].last;
                void'(src_q1.pop_front());
            end
            cyc++;
        end
        chk("timeout", 128'(cyc < budget), 128'(1));
        @(negedge log_clk);
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        tresp_tready_in = 1'b1;
        stall_lo = 0;
        stall_hi = 0;
        #1;
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_grant", 128'(grant), 128'(0));
        chk("end_cnt0", 128'(pkt_cnt0), 128'(cnt_m0));
        chk("end_cnt1", 128'(pkt_cnt1), 128'(cnt_m1));
    endtask

    initial begin
        beat_t b;

        // Reset state
        do_reset();
        #1;
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_tready", 128'({s0_tready, s1_tready}), 128'(0));
        chk("rst_out", 128'({tresp_tvalid_o, tresp_tlast_o, tresp_tdata_o, tresp_tkeep_o,
                              tresp_tuser_o}), 128'(0));
        chk("rst_cnt", 128'({pkt_cnt0, pkt_cnt1}), 128'(0));

        // Single doorbell from s0 with latency checks
        @(negedge log_clk);
        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'h00A0_0040_0100_0000;
        s0_tkeep = 8'hFF; s0_tuser = 32'h0001_0002; tresp_tready_in = 1'b1;
        #1;
        chk("db_arb_grant", 128'(grant), 128'(0));
        chk("db_arb_tready", 128'(s0_tready), 128'(0));
        @(negedge log_clk); #1;
        chk("db_grant", 128'(grant), 128'(2'b01));
        chk("db_tready", 128'({s0_tready, s1_tready}), 128'(2'b10));
        @(negedge log_clk);
        s0_tvalid = 1'b0;
        #1;
        chk("db_out", 128'({tresp_tvalid_o, tresp_tdata_o, tresp_tkeep_o, tresp_tuser_o,
                             tresp_tlast_o}),
            128'({1'b1, 64'h00A0_0040_0100_0000, 8'hFF, 32'h0001_0002, 1'b1}));
        chk("db_grant_clr", 128'(grant), 128'(0));
        @(negedge log_clk); #1;
        chk("db_cnt0", 128'(pkt_cnt0), 128'(1));
        chk("db_out_empty", 128'(tresp_tvalid_o), 128'(0));
        chk("db_busy", 128'(busy), 128'(0));

        // Simultaneous requests after reset: s0 4 beats then s1 2 beats
        do_reset();
        ready_pct = 100; gap_pct = 0;
        add_packet(0, 4);
        add_packet(1, 2);
        run_phase(200);

        // Backpressure mid s1 8-beat packet
        add_packet(1, 8);
        stall_lo = 5; stall_hi = 10;
        run_phase(200);

        // Fairness: 10 single-beat packets per source, strict alternation
        for (int i = 0; i < 10; i++) begin
            add_packet(0, 1);
            add_packet(1, 1);
        end
        run_phase(400);

        // Random traffic with backpressure and mid-packet gaps
        ready_pct = 70; gap_pct = 20;
        for (int i = 0; i < 15; i++) begin
            add_packet(0, $urandom_range(6, 1));
            add_packet(1, $urandom_range(6, 1));
        end
        run_phase(3000);

        // Counter wrap on source 0
        ready_pct = 100; gap_pct = 0;
        @(negedge log_clk);
        force dut.cnt0_q = 16'hFFFE;
        @(negedge log_clk);
        release dut.cnt0_q;
        cnt_m0 = 16'hFFFE;
        #1;
        chk("wrap_preload", 128'(pkt_cnt0), 128'(16'hFFFE));
        for (int i = 0; i < 3; i++) add_packet(0, 1);
        run_phase(200);
        chk("wrap_final", 128'(pkt_cnt0), 128'(16'h0001));

        // Reset on beat 2 of a 4-beat s1 packet
        do_reset();
        tresp_tready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge log_clk);
            b.data = {$urandom, $urandom};
            s1_tvalid = 1'b1; s1_tdata = b.data; s1_tkeep = 8'hFF;
            s1_tuser = 32'h0003_0004; s1_tlast = 1'b0;
            if (i == 3) log_rst = 1'b1;
        end
        @(negedge log_clk);
        s1_tvalid = 1'b0;
        #1;
        chk("rmid_out", 128'({tresp_tvalid_o, tresp_tlast_o, tresp_tdata_o, tresp_tkeep_o,
                               tresp_tuser_o}), 128'(0));
        chk("rmid_grant", 128'(grant), 128'(0));
        chk("rmid_busy", 128'(busy), 128'(0));
        chk("rmid_tready", 128'({s0_tready, s1_tready}), 128'(0));
        chk("rmid_cnt", 128'({pkt_cnt0, pkt_cnt1}), 128'(0));
        log_rst = 1'b0;
        last_src_m = 1;
        cnt_m0 = 16'h0;
        cnt_m1 = 16'h0;
        add_packet(0, 3);
        run_phase(200);
        chk("rmid_cnt1", 128'(pkt_cnt1), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
